uart_rx_sampler: RTL and testbench

// - UART receive front-end; sits directly upstream of the 8-bit serial-in/parallel-out shift register.
// - Synchronises and oversamples the raw rxd line, detects start bits and samples each data bit at mid-bit.
// - Drives that register: shift_bit goes to its serial data input, shift_en qualifies its shift.
// - Also assembles the byte LSB-first internally and flags framing errors.

---
 rtl/uart_pkg.sv | 5 +
 rtl/uart_rx_sampler_if.sv | 14 +
 rtl/uart_baud_tick.sv | 17 +
 rtl/uart_rx_sampler.sv | 114 +++++++++++
 tb/tb_uart_rx_sampler.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver FSM state encoding and frame constants.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
    localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/uart_rx_sampler_if.sv
// uart_rx_sampler_if: serial line input and receive-side outputs of uart_rx_sampler.
// UART_RX_PARITY_EN adds the parity_err output.
interface uart_rx_sampler_if;
    logic rxd, shift_en, shift_bit, rx_valid, frame_err, busy;
    logic [7:0] rx_data;
`ifdef UART_RX_PARITY_EN
    logic parity_err;
    modport master(input rxd, output shift_en, shift_bit, rx_data, rx_valid, frame_err, busy, parity_err);
    modport slave(output rxd, input shift_en, shift_bit, rx_data, rx_valid, frame_err, busy, parity_err);
`else
    modport master(input rxd, output shift_en, shift_bit, rx_data, rx_valid, frame_err, busy);
    modport slave(output rxd, input shift_en, shift_bit, rx_data, rx_valid, frame_err, busy);
`endif
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running oversample tick divider with synchronous phase restart.
module uart_baud_tick #(
    parameter int BAUD_DIV = 27
) (
    input  logic clk,
    input  logic clr,
    input  logic restart,
    output logic tick
);
    localparam int W = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(BAUD_DIV - 1);
    logic [W-1:0] cnt;
    assign tick = cnt == LAST;
    always_ff @(posedge clk or posedge clr)
        if (clr) cnt <= '0;
        else cnt <= (restart || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampling UART receive front-end feeding a downstream SIPO register.
// Define UART_RX_PARITY_EN for 8E1/8O1 frames with a parity_err output (8N1 otherwise).
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 27,
    parameter int OVS      = 16,
    parameter int SYNC_LEN = 2
`ifdef UART_RX_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input logic clk,
    input logic clr,
    uart_rx_sampler_if.master bus
);
    localparam int TW = $clog2(OVS);
    localparam logic [TW-1:0] HALF = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] FULL = TW'(OVS - 1);
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_t state;
    logic [SYNC_LEN-1:0] sync;
    logic line, line_d, tick, start, sample;
    logic [TW-1:0] tcnt;
    logic [2:0] bcnt;
    logic [UART_DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
    logic par;
`endif

    assign line = sync[SYNC_LEN-1];
    assign start = state == IDLE && line_d && !line;
    // The start bit is resampled at half a bit; every later bit one full bit after that.
    assign sample = tick && tcnt == (state == START ? HALF : FULL);

    uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
        .clk(clk),
        .clr(clr),
        .restart(start),
        .tick(tick)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync          <= '1;
            line_d        <= 1'b1;
            state         <= IDLE;
            tcnt          <= '0;
            bcnt          <= '0;
            shreg         <= '0;
            bus.shift_en  <= 1'b0;
            bus.shift_bit <= 1'b0;
            bus.rx_data   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par            <= 1'b0;
            bus.parity_err <= 1'b0;
`endif
        end else begin
            sync          <= {sync[SYNC_LEN-2:0], bus.rxd};
            line_d        <= line;
            bus.shift_en  <= 1'b0;
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            bus.parity_err <= 1'b0;
`endif
            if (state != IDLE && tick) tcnt <= sample ? '0 : tcnt + 1'b1;
            case (state)
                IDLE: if (start) begin
                    state    <= START;
                    bus.busy <= 1'b1;
                    tcnt     <= '0;
                end
                START: if (sample) begin
                    state    <= line ? IDLE : DATA;
                    bus.busy <= !line;
                    bcnt     <= '0;
                end
                DATA: if (sample) begin
                    bus.shift_en  <= 1'b1;
                    bus.shift_bit <= line;
                    shreg         <= {line, shreg[UART_DATA_BITS-1:1]};
                    bcnt          <= bcnt + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bcnt == LAST_BIT) state <= PARITY;
`else
                    if (bcnt == LAST_BIT) state <= STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (sample) begin
                    par   <= line;
                    state <= STOP;
                end
`endif
                STOP: if (sample) begin
                    if (line) bus.rx_data <= shreg;
                    bus.rx_valid  <= line;
                    bus.frame_err <= !line;
`ifdef UART_RX_PARITY_EN
                    bus.parity_err <= (^shreg ^ par) != PARITY_ODD;
`endif
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: directed and randomized UART frames; expected bits and frame results are
// queued at send time and a separate monitor pops and compares them as the DUT pulses.
`timescale 1ns/1ps
module tb_uart_rx_sampler;
    localparam int BIT = 64;
    typedef struct {
        bit ferr;
        bit perr;
        bit [7:0] data;
    } res_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int total = 0;
    int bad = 0;
    bit sq[$];
    res_t rq[$];
    res_t r;
    bit [7:0] last_good = 8'h00;
    bit [7:0] d;
    bit stp, bp;
    int per;

    uart_rx_sampler_if bus();
    uart_rx_sampler #(.BAUD_DIV(4), .OVS(16), .SYNC_LEN(2)) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.shift_en, bus.shift_bit, bus.rx_data, bus.rx_valid, bus.frame_err, bus.busy});
    endfunction

    task automatic tx_bit(input bit b, input int p);
        bus.rxd = b;
        repeat (p) @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Reference: a good frame yields its 8 data bits LSB first, then one result pulse.
    task automatic send(input bit [7:0] dat, input bit stop, input bit bad_par, input int p);
        res_t e;
        for (int i = 0; i < 8; i++) sq.push_back(dat[i]);
        e.ferr = !stop;
        e.perr = bad_par;
        e.data = dat;
        rq.push_back(e);
        tx_bit(1'b0, p);
        for (int i = 0; i < 8; i++) tx_bit(dat[i], p);
`ifdef UART_RX_PARITY_EN
        tx_bit(^dat ^ bad_par, p);
`endif
        tx_bit(stop, p);
    endtask

    always @(negedge clk) begin
        if (clr) last_good = 8'h00;
        else begin
            if (bus.shift_en) begin
                chk("shift_en expected", 32'(sq.size() > 0), 1);
                if (sq.size() > 0) chk("shift_bit", bus.shift_bit, sq.pop_front());
            end
            if (bus.rx_valid || bus.frame_err) begin
                chk("valid/ferr exclusive", bus.rx_valid & bus.frame_err, 0);
                chk("frame pulse expected", 32'(rq.size() > 0), 1);
                if (rq.size() > 0) begin
                    r = rq.pop_front();
                    chk("frame_err", bus.frame_err, r.ferr);
                    if (!r.ferr) last_good = r.data;
                    chk("rx_data", bus.rx_data, last_good);
`ifdef UART_RX_PARITY_EN
                    chk("parity_err", bus.parity_err, r.perr);
`endif
                end
            end
        end
    end

    initial begin
        bus.rxd = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset outputs", outs(), 0);
        clr = 1'b0;
        idle(500);
        chk("idle busy", bus.busy, 0);
        send(8'hA5, 1'b1, 1'b0, BIT);
        idle(20);
        chk("busy after A5", bus.busy, 0);
        chk("rx_data A5", bus.rx_data, 8'hA5);
        bus.rxd = 1'b0;
        repeat (20) @(negedge clk);
        idle(100);
        chk("busy after glitch", bus.busy, 0);
        send(8'h3C, 1'b0, 1'b0, BIT);
        idle(100);
        chk("rx_data after frame_err", bus.rx_data, 8'hA5);
        send(8'h00, 1'b1, 1'b0, BIT);
        send(8'hFF, 1'b1, 1'b0, BIT);
        idle(100);
        chk("rx_data back-to-back", bus.rx_data, 8'hFF);
        send(8'h00, 1'b1, 1'b0, BIT - 2);
        send(8'hFF, 1'b1, 1'b0, BIT - 2);
        send(8'h00, 1'b1, 1'b0, BIT + 2);
        send(8'hFF, 1'b1, 1'b0, BIT + 2);
        idle(100);
        // Abort a frame of 8'hC3 after four data bits have been shifted out.
        d = 8'hC3;
        for (int i = 0; i < 4; i++) sq.push_back(d[i]);
        tx_bit(1'b0, BIT);
        for (int i = 0; i < 4; i++) tx_bit(d[i], BIT);
        bus.rxd = d[4];
        repeat (10) @(negedge clk);
        chk("busy mid-frame", bus.busy, 1);
        #2 clr = 1'b1;
        #1 chk("async clear outputs", outs(), 0);
        repeat (2) @(negedge clk);
        clr = 1'b0;
        idle(50);
        send(8'h5A, 1'b1, 1'b0, BIT);
        idle(100);
        chk("rx_data after abort", bus.rx_data, 8'h5A);
`ifdef UART_RX_PARITY_EN
        send(8'h96, 1'b1, 1'b1, BIT);
        idle(100);
`endif
        for (int n = 0; n < 40; n++) begin
            d = 8'($urandom);
            stp = $urandom_range(0, 9) != 0;
            bp = $urandom_range(0, 3) == 0;
            per = $urandom_range(BIT - 2, BIT + 2);
            if ($urandom_range(0, 4) == 0) begin
                bus.rxd = 1'b0;
                repeat ($urandom_range(2, 24)) @(negedge clk);
                idle(60);
            end
            send(d, stp, bp, per);
            idle(stp ? $urandom_range(0, 40) : $urandom_range(20, 60));
        end
        idle(200);
        for (int i = 0; i < 2000 && (sq.size() > 0 || rq.size() > 0); i++) @(negedge clk);
        chk("bits left", sq.size(), 0);
        chk("frames left", rq.size(), 0);
        chk("final busy", bus.busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
